// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one UART TX FIFO write port among N_REQ byte
// producers. Each grant costs three cycles (IDLE, WRITE, SETTLE). After the
// last index is served, a fixed idle gap paces the link before the next round.
module uart_tx_scheduler #(
  parameter int N_REQ      = 4,
  parameter int GAP_CYCLES = 600,
  parameter int GAP_W      = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic               tx_full,
  output logic [N_REQ-1:0]   ack,
  output logic               wr_uart,
  output logic [7:0]         w_data,
  output logic [2:0]         grant_id,
  output logic               busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [2:0]       LAST_ID  = 3'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, WRITE, SETTLE, GAP} state_t;

  state_t             r_state, w_state_d;
  logic [PW-1:0]      r_rr_ptr;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [N_REQ-1:0]   r_ack;
  logic               r_wr;
  logic [7:0]         r_data;
  logic [2:0]         r_grant;
  logic               r_busy;

  logic               w_found;
  logic [PW-1:0]      w_win;
  logic               w_go;
  logic [PW-1:0]      w_rr_next;

  // Rotating priority search: first pending request starting at r_rr_ptr.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = (int'(r_rr_ptr) + k) % N_REQ;
      if (!w_found && req[idx]) begin
        w_found = 1'b1;
        w_win   = PW'(idx);
      end
    end
  end

  // A grant is only taken from IDLE with room in the FIFO.
  assign w_go      = (r_state == IDLE) && w_found && !tx_full;
  assign w_rr_next = (int'(w_win) == N_REQ - 1) ? '0 : w_win + 1'b1;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_d;
  end

  // Next-state logic; the gap is entered only after serving the last index.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      IDLE:    if (w_go) w_state_d = WRITE;
      WRITE:   w_state_d = SETTLE;
      SETTLE:  w_state_d = (r_grant == LAST_ID && GAP_CYCLES > 0) ? GAP : IDLE;
      GAP:     if (r_gap_cnt == GAP_LAST) w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  // Registered outputs, round-robin pointer and gap counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr  <= '0;
      r_gap_cnt <= '0;
      r_ack     <= '0;
      r_wr      <= 1'b0;
      r_data    <= '0;
      r_grant   <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_ack  <= '0;
      r_wr   <= 1'b0;
      r_busy <= (w_state_d != IDLE);
      if (w_go) begin
        r_ack[w_win] <= 1'b1;
        r_wr         <= 1'b1;
        r_data       <= req_data[8*w_win +: 8];
        r_grant      <= 3'(w_win);
        r_rr_ptr     <= w_rr_next;
      end
      if (r_state == GAP) begin
        if (r_gap_cnt == GAP_LAST) r_gap_cnt <= '0;
        else                       r_gap_cnt <= r_gap_cnt + 1'b1;
      end else begin
        r_gap_cnt <= '0;
      end
    end
  end

  assign ack      = r_ack;
  assign wr_uart  = r_wr;
  assign w_data   = r_data;
  assign grant_id = r_grant;
  assign busy     = r_busy;

endmodule
